stream_gearbox: RTL and testbench

Parametrised bit-stream width converter for the RX chain: it accepts IN_WIDTH-bit symbols and emits OUT_WIDTH-bit words over AXI-Stream-style valid/ready handshakes. It generalises the fixed 2-to-1 resizer that sits between the physical receiver and the BCH decoder. It adds:
- arbitrary width ratios and a configurable bit buffer;
- an input ready that is actually honoured;
- a sticky overflow flag for upstream sources that cannot stall;
- a flush mode that zero-pads and emits a trailing partial word.

---
 rtl/stream_gearbox.sv | 121 ++++++++++++
 tb/tb_stream_gearbox.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_gearbox.sv
// rtl/stream_gearbox.sv - parametrised bit-stream width converter with flush and sticky overflow
//
// Purpose: accepts IN_WIDTH-bit symbols and emits OUT_WIDTH-bit words, preserving
// bit order (bit 0 is the earliest bit on both sides). A flush request drains the
// buffer, presenting a trailing partial word zero-padded. Symbols offered while
// in_ready=0 are dropped and latch a sticky overflow flag.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   input symbol valid
//   in_data    input symbol [IN_WIDTH-1:0]
//   in_ready   block can accept one full symbol (state only, no path from out_ready)
//   out_valid  output word valid
//   out_data   output word [OUT_WIDTH-1:0], bits at positions >= level forced to 0
//   out_ready  downstream accepts the word
//   flush      single-cycle drain request
//   overflow   sticky: a symbol was offered while in_ready=0
//   level      number of valid bits held [LW-1:0]

module stream_gearbox #(
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 1,
   parameter int BUF_BITS  = 8,
   parameter int LW        = $clog2(BUF_BITS + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [OUT_WIDTH-1:0] out_data,
   input  logic                 out_ready,
   input  logic                 flush,
   output logic                 overflow,
   output logic [LW-1:0]        level
);

   generate
      if (BUF_BITS < IN_WIDTH + OUT_WIDTH) begin : g_bad_cfg
         $error("stream_gearbox: BUF_BITS must be >= IN_WIDTH + OUT_WIDTH");
      end
   endgenerate

   localparam logic [LW-1:0] IN_L  = LW'(IN_WIDTH);
   localparam logic [LW-1:0] OUT_L = LW'(OUT_WIDTH);
   localparam logic [LW-1:0] BUF_L = LW'(BUF_BITS);

   logic [BUF_BITS-1:0] sreg;
   logic [BUF_BITS-1:0] sreg_nxt;
   logic [BUF_BITS-1:0] shifted;
   logic [BUF_BITS-1:0] in_mask;
   logic [BUF_BITS-1:0] in_bits;
   logic [LW-1:0]       cnt;
   logic [LW-1:0]       cnt_nxt;
   logic [LW-1:0]       cnt_mid;
   logic [LW-1:0]       shamt;
   logic                fp;
   logic                ovf;
   logic                out_fire;
   logic                in_fire;

   assign in_ready  = !fp && ((BUF_L - cnt) >= IN_L);
   assign out_valid = (cnt >= OUT_L) || (fp && (cnt != '0));
   assign out_fire  = out_valid && out_ready;
   assign in_fire   = in_valid && in_ready;
   assign overflow  = ovf;
   assign level     = cnt;

   // Bits at or above cnt are stale; mask them so a partial word is zero-padded
   // and an empty buffer shows all zeros.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         out_data[i] = sreg[i] && (LW'(i) < cnt);
      end
   end

   // Output is consumed first, so the incoming symbol lands right after the
   // bits that remain once the outgoing word has been shifted away.
   always_comb begin
      shamt = '0;
      if (out_fire) begin
         shamt = (cnt >= OUT_L) ? OUT_L : cnt;
      end
      shifted  = sreg >> shamt;
      cnt_mid  = cnt - shamt;
      in_mask  = BUF_BITS'({IN_WIDTH{1'b1}}) << cnt_mid;
      in_bits  = BUF_BITS'(in_data) << cnt_mid;
      sreg_nxt = shifted;
      cnt_nxt  = cnt_mid;
      if (in_fire) begin
         sreg_nxt = (shifted & ~in_mask) | in_bits;
         cnt_nxt  = cnt_mid + IN_L;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
         fp   <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         sreg <= sreg_nxt;
         cnt  <= cnt_nxt;
         // A flush seen while one is pending is ignored; pending clears once
         // the buffer is empty (one edge later if it was already empty).
         if (fp) begin
            fp <= (cnt_nxt != '0);
         end else begin
            fp <= flush;
         end
         if (in_valid && !in_ready) begin
            ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_gearbox.sv
// tb/tb_stream_gearbox.sv - scoreboard bench for stream_gearbox in three width configurations

module tb_stream_gearbox;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // instance A: IN=2 OUT=1 BUF=8
   logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_overflow;
   logic [1:0] a_in_data;
   logic [0:0] a_out_data, a_exp;
   logic [3:0] a_level;
   // instance B: IN=3 OUT=2 BUF=8
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_overflow;
   logic [2:0] b_in_data;
   logic [1:0] b_out_data, b_exp;
   logic [3:0] b_level;
   // instance C: IN=5 OUT=3 BUF=16
   logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush, c_overflow;
   logic [4:0] c_in_data;
   logic [2:0] c_out_data, c_exp, c_hold;
   logic [4:0] c_level;
   logic       c_stall;

   logic       qa[$];
   logic       qb[$];
   logic       qc[$];
   logic       a_got[$];
   logic [1:0] b_got[$];
   logic [2:0] c_got[$];

   stream_gearbox #(.IN_WIDTH(2), .OUT_WIDTH(1), .BUF_BITS(8)) u_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
      .flush(a_flush), .overflow(a_overflow), .level(a_level));

   stream_gearbox #(.IN_WIDTH(3), .OUT_WIDTH(2), .BUF_BITS(8)) u_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
      .flush(b_flush), .overflow(b_overflow), .level(b_level));

   stream_gearbox #(.IN_WIDTH(5), .OUT_WIDTH(3), .BUF_BITS(16)) u_c (
      .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
      .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
      .flush(c_flush), .overflow(c_overflow), .level(c_level));

   // Monitors: sample on the falling edge, pop expected bits for an output fire
   // (zero-padding a short tail), then push the bits of an accepted symbol.
   always @(negedge clk) begin
      if (rst) begin
         qa.delete();
      end else begin
         if (a_out_valid && a_out_ready) begin
            a_exp = '0;
            for (int i = 0; i < 1; i++) if (qa.size() > 0) a_exp[i] = qa.pop_front();
            check("a_sb_word", 32'(a_out_data), 32'(a_exp));
            a_got.push_back(a_out_data[0]);
         end
         if (a_in_valid && a_in_ready)
            for (int i = 0; i < 2; i++) qa.push_back(a_in_data[i]);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         qb.delete();
      end else begin
         if (b_out_valid && b_out_ready) begin
            b_exp = '0;
            for (int i = 0; i < 2; i++) if (qb.size() > 0) b_exp[i] = qb.pop_front();
            check("b_sb_word", 32'(b_out_data), 32'(b_exp));
            b_got.push_back(b_out_data);
         end
         if (b_in_valid && b_in_ready)
            for (int i = 0; i < 3; i++) qb.push_back(b_in_data[i]);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         qc.delete();
         c_stall = 1'b0;
      end else begin
         if (c_stall) begin
            check("c_hold_valid", 32'(c_out_valid), 32'd1);
            check("c_hold_data", 32'(c_out_data), 32'(c_hold));
         end
         c_stall = c_out_valid && !c_out_ready;
         c_hold  = c_out_data;
         if (c_out_valid && c_out_ready) begin
            c_exp = '0;
            for (int i = 0; i < 3; i++) if (qc.size() > 0) c_exp[i] = qc.pop_front();
            check("c_sb_word", 32'(c_out_data), 32'(c_exp));
            c_got.push_back(c_out_data);
         end
         if (c_in_valid && c_in_ready)
            for (int i = 0; i < 5; i++) qc.push_back(c_in_data[i]);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a_bits;
      logic [1:0] a_syms[4];
      logic [1:0] b_exp3[3];

      a_in_valid = 0; a_in_data = '0; a_out_ready = 0; a_flush = 0;
      b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0;
      c_in_valid = 0; c_in_data = '0; c_out_ready = 0; c_flush = 0;
      c_stall = 0; c_hold = '0;
      a_exp = '0; b_exp = '0; c_exp = '0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // reset state
      @(negedge clk);
      check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
      check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_a_out_data", 32'(a_out_data), 32'd0);
      check("rst_a_level", 32'(a_level), 32'd0);
      check("rst_a_overflow", 32'(a_overflow), 32'd0);
      check("rst_c_in_ready", 32'(c_in_ready), 32'd1);
      check("rst_c_level", 32'(c_level), 32'd0);

      // A: symbol 2'b10 -> bits 0 then 1, level 2,1,0
      step();
      a_out_ready = 1; a_in_valid = 1; a_in_data = 2'b10;
      step();
      a_in_valid = 0;
      @(negedge clk);
      check("t1_level2", 32'(a_level), 32'd2);
      check("t1_valid", 32'(a_out_valid), 32'd1);
      check("t1_data0", 32'(a_out_data), 32'd0);
      step();
      @(negedge clk);
      check("t1_level1", 32'(a_level), 32'd1);
      check("t1_data1", 32'(a_out_data), 32'd1);
      step();
      @(negedge clk);
      check("t1_level0", 32'(a_level), 32'd0);
      check("t1_valid_off", 32'(a_out_valid), 32'd0);
      check("t1_overflow", 32'(a_overflow), 32'd0);

      // A: fill with out_ready=0, then overflow on the fifth offer, then drain
      step();
      a_got.delete();
      a_syms[0] = 2'b01; a_syms[1] = 2'b11; a_syms[2] = 2'b00; a_syms[3] = 2'b10;
      a_out_ready = 0; a_in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         a_in_data = a_syms[i];
         step();
      end
      a_in_data = 2'b11;
      @(negedge clk);
      check("full_level", 32'(a_level), 32'd8);
      check("full_in_ready", 32'(a_in_ready), 32'd0);
      check("full_no_ovf_yet", 32'(a_overflow), 32'd0);
      step();
      a_in_valid = 0;
      @(negedge clk);
      check("full_ovf", 32'(a_overflow), 32'd1);
      check("full_level_kept", 32'(a_level), 32'd8);
      step();
      a_out_ready = 1;
      repeat (12) step();
      @(negedge clk);
      check("drain_level", 32'(a_level), 32'd0);
      check("drain_count", 32'(a_got.size()), 32'd8);
      a_bits = '0;
      for (int i = 0; i < 8; i++) if (i < a_got.size()) a_bits[i] = a_got[i];
      check("drain_bits", 32'(a_bits), 32'h8D);
      check("drain_ovf_sticky", 32'(a_overflow), 32'd1);

      // B: 3'b101, 3'b011 -> 01, 11, 01
      step();
      b_got.delete();
      b_out_ready = 1; b_in_valid = 1; b_in_data = 3'b101;
      step();
      b_in_data = 3'b011;
      step();
      b_in_valid = 0;
      repeat (3) step();
      @(negedge clk);
      b_exp3[0] = 2'b01; b_exp3[1] = 2'b11; b_exp3[2] = 2'b01;
      check("t2_level", 32'(b_level), 32'd0);
      check("t2_count", 32'(b_got.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         check("t2_word", (i < b_got.size()) ? 32'(b_got[i]) : 32'hxxxx_xxxx, 32'(b_exp3[i]));

      // B: 3'b111 then flush -> 11, then padded 01
      step();
      b_got.delete();
      b_in_valid = 1; b_in_data = 3'b111;
      step();
      b_in_valid = 0; b_flush = 1;
      step();
      b_flush = 0;
      @(negedge clk);
      check("fl_in_ready_low", 32'(b_in_ready), 32'd0);
      check("fl_partial_valid", 32'(b_out_valid), 32'd1);
      check("fl_partial_data", 32'(b_out_data), 32'd1);
      check("fl_level1", 32'(b_level), 32'd1);
      step();
      @(negedge clk);
      check("fl_in_ready_back", 32'(b_in_ready), 32'd1);
      check("fl_valid_off", 32'(b_out_valid), 32'd0);
      check("fl_level0", 32'(b_level), 32'd0);
      check("fl_count", 32'(b_got.size()), 32'd2);
      check("fl_word0", (b_got.size() > 0) ? 32'(b_got[0]) : 32'hxxxx_xxxx, 32'd3);
      check("fl_word1", (b_got.size() > 1) ? 32'(b_got[1]) : 32'hxxxx_xxxx, 32'd1);

      // B: flush on empty buffer blocks input one cycle; offer during it overflows
      step();
      b_flush = 1;
      step();
      b_flush = 0; b_in_valid = 1; b_in_data = 3'b010;
      @(negedge clk);
      check("fe_in_ready_low", 32'(b_in_ready), 32'd0);
      check("fe_valid_off", 32'(b_out_valid), 32'd0);
      check("fe_no_ovf_yet", 32'(b_overflow), 32'd0);
      step();
      b_in_valid = 0;
      @(negedge clk);
      check("fe_in_ready_back", 32'(b_in_ready), 32'd1);
      check("fe_ovf", 32'(b_overflow), 32'd1);
      check("fe_level", 32'(b_level), 32'd0);

      // C: random valid/ready, source honours in_ready
      step();
      for (int n = 0; n < 400; n++) begin
         c_out_ready = 1'($urandom_range(0, 1));
         c_in_valid  = ($urandom_range(0, 2) != 0) && c_in_ready;
         c_in_data   = 5'($urandom);
         step();
      end
      c_in_valid = 0; c_out_ready = 1;
      repeat (10) step();
      c_flush = 1;
      step();
      c_flush = 0;
      repeat (4) step();
      @(negedge clk);
      check("rnd_sb_empty", 32'(qc.size()), 32'd0);
      check("rnd_level", 32'(c_level), 32'd0);
      check("rnd_no_ovf", 32'(c_overflow), 32'd0);
      check("rnd_valid_off", 32'(c_out_valid), 32'd0);
      check("rnd_in_ready", 32'(c_in_ready), 32'd1);

      // C: async reset with level=5 and flush pending
      step();
      c_out_ready = 0; c_in_valid = 1; c_in_data = 5'b10011;
      step();
      c_in_valid = 0; c_flush = 1;
      step();
      c_flush = 0;
      @(negedge clk);
      check("pre_rst_level", 32'(c_level), 32'd5);
      check("pre_rst_fp_block", 32'(c_in_ready), 32'd0);
      step();
      #1 rst = 1;
      #1;
      check("ar_valid", 32'(c_out_valid), 32'd0);
      check("ar_data", 32'(c_out_data), 32'd0);
      check("ar_level", 32'(c_level), 32'd0);
      check("ar_in_ready", 32'(c_in_ready), 32'd1);
      check("ar_ovf_c", 32'(c_overflow), 32'd0);
      check("ar_ovf_a", 32'(a_overflow), 32'd0);
      check("ar_ovf_b", 32'(b_overflow), 32'd0);
      #10 rst = 0;
      step();
      c_got.delete();
      c_out_ready = 1; c_in_valid = 1; c_in_data = 5'b10110;
      step();
      c_in_valid = 0; c_flush = 1;
      step();
      c_flush = 0;
      repeat (3) step();
      @(negedge clk);
      check("post_rst_count", 32'(c_got.size()), 32'd2);
      check("post_rst_word0", (c_got.size() > 0) ? 32'(c_got[0]) : 32'hxxxx_xxxx, 32'd6);
      check("post_rst_word1", (c_got.size() > 1) ? 32'(c_got[1]) : 32'hxxxx_xxxx, 32'd2);
      check("post_rst_level", 32'(c_level), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
